// File: rtl/tl_release_scheduler.sv
// Credit-aware, message-locking round-robin scheduler for the release path.
// Holds the grant across all beats of a data message and escalates starved requesters.
module tl_starve_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       valid,
  input  logic       granted,
  output logic [7:0] count
);
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (start) begin
      if (granted)
        count <= '0;
      else if (valid && count != 8'hff)
        count <= count + 8'd1;
    end
  end
endmodule

module tl_release_scheduler #(
  parameter int N_IN         = 4,
  parameter int W            = 101,
  parameter int BEATS        = 8,
  parameter int CREDITS      = 4,
  parameter int STARVE_LIMIT = 16,
  localparam int CW  = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int BW  = $clog2(BEATS),
  localparam int CRW = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IN-1:0]   in_valid,
  input  logic [N_IN-1:0]   in_has_data,
  input  logic [N_IN*W-1:0] in_payload,
  output logic [N_IN-1:0]   in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_payload,
  output logic [CW-1:0]     out_chosen,
  output logic              out_last,
  input  logic              credit_return,
  output logic              credit_overflow
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state;
  logic [CW-1:0]          lock_idx, last_grant, pick;
  logic [BW-1:0]          beat_cnt;
  logic [CRW-1:0]         credits;
  logic [N_IN-1:0][7:0]   starve;
  logic                   found, can_send, fire, start;

  // Escalated requesters first, then round robin after last_grant, then wrap to lowest.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_IN; i++)
      if (!found && in_valid[i] && starve[i] >= 8'(STARVE_LIMIT)) begin
        pick  = CW'(i);
        found = 1'b1;
      end
    for (int i = 0; i < N_IN; i++)
      if (!found && in_valid[i] && i > int'(last_grant)) begin
        pick  = CW'(i);
        found = 1'b1;
      end
    for (int i = 0; i < N_IN; i++)
      if (!found && in_valid[i]) begin
        pick  = CW'(i);
        found = 1'b1;
      end
  end

  assign out_chosen  = (state == LOCKED) ? lock_idx : pick;
  assign can_send    = (credits != '0);
  assign out_valid   = in_valid[out_chosen] & can_send & ~reset;
  assign out_payload = in_payload[int'(out_chosen)*W +: W];
  assign out_last    = (state == LOCKED) ? (beat_cnt == BW'(BEATS-1)) : ~in_has_data[out_chosen];
  assign fire        = out_valid & out_ready;
  assign start       = fire & (state == IDLE);

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_IN; i++)
      in_ready[i] = (out_chosen == CW'(i)) & out_ready & can_send & ~reset;
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_starve
    tl_starve_ctr u_ctr (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .valid   (in_valid[g]),
      .granted (out_chosen == CW'(g)),
      .count   (starve[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      lock_idx        <= '0;
      beat_cnt        <= '0;
      last_grant      <= CW'(N_IN-1);
      credits         <= CRW'(CREDITS);
      credit_overflow <= 1'b0;
    end else begin
      if (start) begin
        last_grant <= out_chosen;
        if (in_has_data[out_chosen]) begin
          state    <= LOCKED;
          lock_idx <= out_chosen;
          beat_cnt <= BW'(1);
        end
      end else if (fire) begin
        // BEATS is a power of two, so the counter wraps to 0 on the final beat.
        beat_cnt <= beat_cnt + BW'(1);
        if (beat_cnt == BW'(BEATS-1))
          state <= IDLE;
      end
      if (fire && !credit_return)
        credits <= credits - CRW'(1);
      else if (credit_return && !fire) begin
        if (credits == CRW'(CREDITS))
          credit_overflow <= 1'b1;
        else
          credits <= credits + CRW'(1);
      end
    end
  end
endmodule
